rob: RTL

ROB -- requirements
Module: rob

---
 rtl/rob.sv | 168 ++++++++++++++++
 1 files changed

// File: rtl/rob.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : rob                                                              |
// | Brief   : Reorder buffer: in-order retire, CDB capture, branch rollback    |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module rob #(
  parameter int ROB_SIZE = 16,
  parameter int TAG_W    = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             rdy,
  input  logic             issue_valid,
  input  logic [1:0]       issue_kind,
  input  logic [4:0]       issue_rd,
  input  logic [31:0]      issue_pc,
  input  logic             issue_predTaken,
  output logic [TAG_W-1:0] issue_tag,
  output logic             rob_full,
  input  logic             cdb_valid,
  input  logic [TAG_W-1:0] cdb_tag,
  input  logic [31:0]      cdb_val,
  input  logic             cdb_taken,
  input  logic [TAG_W-1:0] query_tag1,
  input  logic [TAG_W-1:0] query_tag2,
  output logic             query_ready1,
  output logic             query_ready2,
  output logic [31:0]      query_val1,
  output logic [31:0]      query_val2,
  output logic             commit_valid,
  output logic [4:0]       commit_rd,
  output logic [TAG_W-1:0] commit_tag,
  output logic [31:0]      commit_val,
  output logic             commit_store,
  output logic             rollback,
  output logic [31:0]      rollback_pc
);

  localparam logic [1:0]     c_KIND_REG    = 2'd0;
  localparam logic [1:0]     c_KIND_BRANCH = 2'd1;
  localparam logic [1:0]     c_KIND_STORE  = 2'd2;
  localparam logic [TAG_W:0] c_FULL_COUNT  = (TAG_W+1)'(ROB_SIZE);

  logic [TAG_W-1:0]  r_head;
  logic [TAG_W-1:0]  r_tail;
  logic [TAG_W:0]    r_count;
  logic [ROB_SIZE-1:0] r_busy;
  logic [ROB_SIZE-1:0] r_ready;
  logic [1:0]        r_kind  [ROB_SIZE];
  logic [4:0]        r_rd    [ROB_SIZE];
  logic [31:0]       r_pc    [ROB_SIZE];
  logic              r_pred  [ROB_SIZE];
  logic              r_taken [ROB_SIZE];
  logic [31:0]       r_val   [ROB_SIZE];

  logic              r_commit_valid;
  logic              r_commit_store;
  logic [4:0]        r_commit_rd;
  logic [TAG_W-1:0]  r_commit_tag;
  logic [31:0]       r_commit_val;
  logic              r_rollback;
  logic [31:0]       r_rollback_pc;

  logic              w_issue_accept;
  logic              w_retire;
  logic              w_cdb_hit;
  logic [1:0]        w_issue_kind;
  logic              w_fwd1;
  logic              w_fwd2;

  assign rob_full       = (r_count == c_FULL_COUNT);
  assign issue_tag      = r_tail;
  assign w_issue_kind   = (issue_kind == 2'd3) ? c_KIND_REG : issue_kind;
  assign w_issue_accept = issue_valid && !rob_full && !r_rollback;
  // Retire looks at the registered ready bit, so a CDB write lands one cycle before retire.
  assign w_retire       = (r_count != '0) && r_ready[r_head] && !r_rollback;
  assign w_cdb_hit      = cdb_valid && r_busy[cdb_tag] && !r_rollback;

  assign w_fwd1       = cdb_valid && (cdb_tag == query_tag1);
  assign w_fwd2       = cdb_valid && (cdb_tag == query_tag2);
  assign query_ready1 = w_fwd1 || r_ready[query_tag1];
  assign query_ready2 = w_fwd2 || r_ready[query_tag2];
  assign query_val1   = w_fwd1 ? cdb_val : (r_ready[query_tag1] ? r_val[query_tag1] : 32'd0);
  assign query_val2   = w_fwd2 ? cdb_val : (r_ready[query_tag2] ? r_val[query_tag2] : 32'd0);

  assign commit_valid = r_commit_valid & rdy;
  assign commit_store = r_commit_store & rdy;
  assign rollback     = r_rollback & rdy;
  assign commit_rd    = r_commit_rd;
  assign commit_tag   = r_commit_tag;
  assign commit_val   = r_commit_val;
  assign rollback_pc  = r_rollback_pc;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_head         <= '0;
      r_tail         <= '0;
      r_count        <= '0;
      r_busy         <= '0;
      r_ready        <= '0;
      r_commit_valid <= 1'b0;
      r_commit_store <= 1'b0;
      r_commit_rd    <= '0;
      r_commit_tag   <= '0;
      r_commit_val   <= '0;
      r_rollback     <= 1'b0;
      r_rollback_pc  <= '0;
    end else if (rdy) begin
      r_commit_valid <= 1'b0;
      r_commit_store <= 1'b0;
      r_rollback     <= 1'b0;
      if (r_rollback) begin
        r_head  <= '0;
        r_tail  <= '0;
        r_count <= '0;
        r_busy  <= '0;
        r_ready <= '0;
      end else begin
        if (w_cdb_hit) begin
          r_ready[cdb_tag] <= 1'b1;
        end
        if (w_issue_accept) begin
          r_busy[r_tail]  <= 1'b1;
          r_ready[r_tail] <= 1'b0;
          r_tail          <= r_tail + TAG_W'(1);
        end
        if (w_retire) begin
          r_busy[r_head]  <= 1'b0;
          r_ready[r_head] <= 1'b0;
          r_head          <= r_head + TAG_W'(1);
          r_commit_tag    <= r_head;
          r_commit_rd     <= r_rd[r_head];
          r_commit_val    <= r_val[r_head];
          r_commit_valid  <= (r_kind[r_head] == c_KIND_REG);
          r_commit_store  <= (r_kind[r_head] == c_KIND_STORE);
          if ((r_kind[r_head] == c_KIND_BRANCH) && (r_taken[r_head] != r_pred[r_head])) begin
            r_rollback    <= 1'b1;
            r_rollback_pc <= r_taken[r_head] ? r_val[r_head] : (r_pc[r_head] + 32'd4);
          end
        end
        case ({w_issue_accept, w_retire})
          2'b10:   r_count <= r_count + (TAG_W+1)'(1);
          2'b01:   r_count <= r_count - (TAG_W+1)'(1);
          default: r_count <= r_count;
        endcase
      end
    end
  end

  // Entry payload needs no reset: busy/ready gate every use of it.
  always_ff @(posedge clk) begin
    if (!rst && rdy) begin
      if (w_cdb_hit) begin
        r_val[cdb_tag]   <= cdb_val;
        r_taken[cdb_tag] <= cdb_taken;
      end
      if (w_issue_accept) begin
        r_kind[r_tail] <= w_issue_kind;
        r_rd[r_tail]   <= issue_rd;
        r_pc[r_tail]   <= issue_pc;
        r_pred[r_tail] <= issue_predTaken;
      end
    end
  end

endmodule
`default_nettype wire
